spio_hss_multiplexer_pkt_distributor: RTL and testbench

SPIO_HSS_MULTIPLEXER_PKT_DISTRIBUTOR -- requirements
Module: spio_hss_multiplexer_pkt_distributor

---
 rtl/spio_hss_multiplexer_pkt_distributor.sv | 130 +++++++++++++
 tb/tb_spio_hss_multiplexer_pkt_distributor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spio_hss_multiplexer_pkt_distributor.sv
// Spreads one packet stream round-robin over per-channel FIFOs feeding the HSS multiplexer.
// Latency 1 cycle input->channel; in_rdy falls when no enabled channel has room, channels stall on pkt_rdy.
`ifndef PKT_BITS
`define PKT_BITS 32
`endif
`ifndef NUM_CHANS
`define NUM_CHANS 8
`endif

module spio_hss_multiplexer_pkt_distributor #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [`PKT_BITS-1:0]             in_data,
   input  logic                             in_vld,
   output logic                             in_rdy,
   input  logic [`NUM_CHANS-1:0]            chan_en,
   output logic [`NUM_CHANS*`PKT_BITS-1:0]  pkt_data,
   output logic [`NUM_CHANS-1:0]            pkt_vld,
   input  logic [`NUM_CHANS-1:0]            pkt_rdy,
   output logic [`NUM_CHANS-1:0]            chan_full,
   output logic [`NUM_CHANS-1:0]            chan_empt,
   output logic [31:0]                      pkt_cnt
);
   localparam int NC = `NUM_CHANS;
   localparam int PW = `PKT_BITS;
   localparam int CW = $clog2(NC);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int OW = AW + 1;

   logic [CW-1:0] rr_ptr;
   logic [CW-1:0] sel;
   logic          sel_found;
   logic          run;
   logic          xfer;
   logic [NC-1:0] eligible;
   logic [NC-1:0] push;
   logic [NC-1:0] pop;

   // run keeps in_rdy low until the first clock edge after reset release
   assign eligible = chan_en & ~chan_full;
   assign in_rdy   = run & (|eligible);
   assign xfer     = in_vld & in_rdy;
   assign pop      = pkt_vld & pkt_rdy;

   always_comb begin
      sel       = rr_ptr;
      sel_found = 1'b0;
      for (int i = 0; i < NC; i++) begin
         if (!sel_found && eligible[rr_ptr + CW'(i)]) begin
            sel       = rr_ptr + CW'(i);
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      push = '0;
      if (xfer) begin
         push[sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run     <= 1'b0;
         rr_ptr  <= '0;
         pkt_cnt <= '0;
      end else begin
         run <= 1'b1;
         if (xfer) begin
            rr_ptr  <= sel + 1'b1;
            pkt_cnt <= pkt_cnt + 32'd1;
         end
      end
   end

   for (genvar n = 0; n < NC; n++) begin : g_chan
      logic [PW-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0] rd_ptr;
      logic [AW-1:0] wr_ptr;
      logic [OW-1:0] occ;
      logic [OW-1:0] occ_nxt;
      logic          full_q;
      logic          empt_q;

      always_comb begin
         occ_nxt = occ;
         if (push[n] && !pop[n]) begin
            occ_nxt = occ + OW'(1);
         end else if (pop[n] && !push[n]) begin
            occ_nxt = occ - OW'(1);
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            full_q <= 1'b0;
            empt_q <= 1'b1;
         end else begin
            occ    <= occ_nxt;
            full_q <= (occ_nxt == OW'(FIFO_DEPTH));
            empt_q <= (occ_nxt == '0);
            if (push[n]) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop[n]) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
      end

      // storage needs no reset: the head is masked to zero whenever the channel is empty
      always_ff @(posedge clk) begin
         if (push[n]) begin
            mem[wr_ptr] <= in_data;
         end
      end

      assign chan_full[n]          = full_q;
      assign chan_empt[n]          = empt_q;
      assign pkt_vld[n]            = ~empt_q;
      assign pkt_data[n*PW +: PW]  = empt_q ? '0 : mem[rd_ptr];
   end

endmodule

// File: tb/tb_spio_hss_multiplexer_pkt_distributor.sv
// Directed and random checks of the packet distributor against a queue-based reference model.
`timescale 1ns/1ps
module tb_spio_hss_multiplexer_pkt_distributor;
   localparam int DEPTH = 2;

   logic         clk;
   logic         rst;
   logic [31:0]  in_data;
   logic         in_vld;
   logic         in_rdy;
   logic [7:0]   chan_en;
   logic [255:0] pkt_data;
   logic [7:0]   pkt_vld;
   logic [7:0]   pkt_rdy;
   logic [7:0]   chan_full;
   logic [7:0]   chan_empt;
   logic [31:0]  pkt_cnt;

   int tests = 0;
   int fails = 0;

   logic [31:0] mq [8][$];
   int          m_rr;
   logic [31:0] m_cnt;
   bit          m_run;

   spio_hss_multiplexer_pkt_distributor #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .chan_en(chan_en), .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
      .chan_full(chan_full), .chan_empt(chan_empt), .pkt_cnt(pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_elig();
      logic [7:0] e;
      for (int n = 0; n < 8; n++) e[n] = chan_en[n] && (mq[n].size() < DEPTH);
      return e;
   endfunction

   task automatic model_reset();
      for (int n = 0; n < 8; n++) mq[n].delete();
      m_rr  = 0;
      m_cnt = 32'd0;
      m_run = 1'b0;
   endtask

   task automatic check_all();
      logic [7:0]   e_vld, e_full, e_empt;
      logic [255:0] e_data;
      e_data = '0;
      for (int n = 0; n < 8; n++) begin
         e_vld[n]  = mq[n].size() > 0;
         e_full[n] = mq[n].size() == DEPTH;
         e_empt[n] = mq[n].size() == 0;
         if (mq[n].size() > 0) e_data[n*32 +: 32] = mq[n][0];
      end
      chk("in_rdy", in_rdy, m_run && (m_elig() != 0));
      chk("pkt_vld", pkt_vld, e_vld);
      chk("pkt_data", pkt_data, e_data);
      chk("chan_full", chan_full, e_full);
      chk("chan_empt", chan_empt, e_empt);
      chk("pkt_cnt", pkt_cnt, m_cnt);
   endtask

   task automatic model_step();
      logic [7:0] elig;
      bit         acc;
      elig = m_elig();
      acc  = m_run && in_vld && (elig != 0);
      for (int n = 0; n < 8; n++)
         if (mq[n].size() > 0 && pkt_rdy[n]) void'(mq[n].pop_front());
      if (acc) begin
         for (int i = 0; i < 8; i++) begin
            int c;
            c = (m_rr + i) % 8;
            if (elig[c]) begin
               mq[c].push_back(in_data);
               m_rr = (c + 1) % 8;
               break;
            end
         end
         m_cnt = m_cnt + 32'd1;
      end
      m_run = 1'b1;
   endtask

   task automatic cycle(input bit v, input logic [31:0] d, input logic [7:0] en, input logic [7:0] rdy);
      in_vld  = v;
      in_data = d;
      chan_en = en;
      pkt_rdy = rdy;
      @(negedge clk);
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] d5, da, db, dd;
      logic [7:0]  cur_en;

      rst = 1'b0; in_vld = 1'b0; in_data = '0; chan_en = 8'hFF; pkt_rdy = 8'h00;
      model_reset();
      #12;
      check_all();
      chk("rst_empt", chan_empt, 8'hFF);
      rst = 1'b1;
      #1;
      chk("rdy_before_edge", in_rdy, 1'b0);
      @(posedge clk);
      #1;
      m_run = 1'b1;

      // back-to-back burst 0..15, all enabled and ready
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, 32'(k), 8'hFF, 8'hFF);
         chk("burst_vld", pkt_vld[k % 8], 1'b1);
         chk("burst_data", pkt_data[(k % 8)*32 +: 32], 32'(k));
      end
      cycle(1'b0, 32'd0, 8'hFF, 8'hFF);
      chk("burst_cnt", pkt_cnt, 32'd16);

      // two enabled channels fill up, fifth packet held
      for (int k = 0; k < 4; k++) cycle(1'b1, $urandom, 8'h05, 8'h00);
      chk("full_mask", chan_full, 8'h05);
      chk("full_rdy", in_rdy, 1'b0);
      d5 = $urandom;
      cycle(1'b1, d5, 8'h05, 8'h00);
      chk("held_cnt", pkt_cnt, 32'd20);
      cycle(1'b1, d5, 8'h05, 8'hFF);
      cycle(1'b1, d5, 8'h05, 8'hFF);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 8'hFF, 8'hFF);

      // full channel 3 popping while the pointer sits on it
      cycle(1'b1, $urandom, 8'h08, 8'h00);
      cycle(1'b1, $urandom, 8'h08, 8'h00);
      cycle(1'b1, $urandom, 8'h04, 8'h00);
      chk("ch3_full", chan_full[3], 1'b1);
      dd = $urandom;
      cycle(1'b1, dd, 8'hFF, 8'h08);
      chk("ch4_vld", pkt_vld[4], 1'b1);
      chk("ch4_data", pkt_data[4*32 +: 32], dd);
      chk("ch3_notfull", chan_full[3], 1'b0);
      chk("ch3_notempt", chan_empt[3], 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 8'hFF, 8'hFF);

      // channel 1 disabled while holding two packets
      da = $urandom; db = $urandom;
      cycle(1'b1, da, 8'h02, 8'h00);
      cycle(1'b1, db, 8'h02, 8'h00);
      cycle(1'b1, $urandom, 8'hFD, 8'h00);
      chk("ch1_head_a", pkt_data[1*32 +: 32], da);
      cycle(1'b1, $urandom, 8'hFD, 8'h02);
      chk("ch1_head_b", pkt_data[1*32 +: 32], db);
      cycle(1'b1, $urandom, 8'hFD, 8'h02);
      chk("ch1_drained", chan_empt[1], 1'b1);
      for (int k = 0; k < 6; k++) cycle(1'b1, $urandom, 8'hFD, 8'($urandom));
      chk("ch1_stays_empty", chan_empt[1], 1'b1);

      // random traffic
      cur_en = 8'hFF;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 7) == 0) cur_en = 8'($urandom);
         cycle($urandom_range(0, 3) != 0, $urandom, cur_en, 8'($urandom));
      end
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 8'hFF, 8'hFF);

      // asynchronous reset mid-burst with three channels occupied
      for (int k = 0; k < 3; k++) cycle(1'b1, $urandom, 8'hFF, 8'h00);
      in_vld = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_vld", pkt_vld, 8'h00);
      chk("arst_rdy", in_rdy, 1'b0);
      chk("arst_cnt", pkt_cnt, 32'd0);
      chk("arst_empt", chan_empt, 8'hFF);
      chk("arst_full", chan_full, 8'h00);
      chk("arst_data", pkt_data, 256'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all();
      @(posedge clk);
      #1;
      m_run = 1'b1;
      cycle(1'b0, 32'd0, 8'hFF, 8'hFF);

      // counter wrap from a preloaded value
      force dut.pkt_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_cnt;
      m_cnt = 32'hFFFF_FFFF;
      cycle(1'b1, $urandom, 8'hFF, 8'hFF);
      chk("wrap0", pkt_cnt, 32'h0000_0000);
      cycle(1'b1, $urandom, 8'hFF, 8'hFF);
      chk("wrap1", pkt_cnt, 32'h0000_0001);
      for (int k = 0; k < 2; k++) cycle(1'b0, 32'd0, 8'hFF, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
